// File: rtl/branch_ctrl.sv
// branch_ctrl: decodes branch/jump micro-ops into the program counter's
// jump interface. It holds a writable jump-target LUT and a hardware
// return-address stack, and keeps flush, sticky stack-error and
// taken-count status.
//
// The jump outputs are combinational, so the PC can sample them at the
// same edge that commits the op. All stored state updates on that edge.
module branch_ctrl #(
  parameter int D        = 12,
  parameter int L        = 5,
  parameter int RS_DEPTH = 4,
  parameter int CW       = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          valid,
  input  logic [2:0]    op,
  input  logic [L-1:0]  lut_idx,
  input  logic          zero_flag,
  input  logic [D-1:0]  prog_ctr,
  input  logic          lut_we,
  input  logic [L-1:0]  lut_waddr,
  input  logic [D-1:0]  lut_wdata,
  output logic          branch_en,
  output logic          reljump_en,
  output logic          absjump_en,
  output logic [D-1:0]  target,
  output logic          flush,
  output logic          rs_overflow,
  output logic          rs_underflow,
  output logic [CW-1:0] taken_cnt
);

  // CNTW must hold the full-stack count RS_DEPTH, so it needs one more code
  // than the number of entries.
  localparam int CNTW = $clog2(RS_DEPTH + 1);
  localparam int IW   = (RS_DEPTH > 1) ? $clog2(RS_DEPTH) : 1;

  localparam logic [2:0] OP_BEQZ = 3'd1;
  localparam logic [2:0] OP_BNEZ = 3'd2;
  localparam logic [2:0] OP_JREL = 3'd3;
  localparam logic [2:0] OP_JABS = 3'd4;
  localparam logic [2:0] OP_CALL = 3'd5;
  localparam logic [2:0] OP_RET  = 3'd6;

  logic [D-1:0]    lut [2**L];
  logic [D-1:0]    rs  [RS_DEPTH];
  logic [CNTW-1:0] rs_cnt;
  logic            rs_full;
  logic            rs_empty;
  logic [IW-1:0]   top_idx;
  logic [IW-1:0]   push_idx;
  logic [D-1:0]    lut_rd;
  logic            do_push;
  logic            do_pop;
  logic            do_ovf;
  logic            do_unf;

  assign rs_full  = (rs_cnt == CNTW'(RS_DEPTH));
  assign rs_empty = (rs_cnt == '0);
  // The top entry sits one below the count. A push writes at the count and
  // only happens when the stack is not full, so that index is always in range.
  assign top_idx  = IW'(rs_cnt - CNTW'(1));
  assign push_idx = IW'(rs_cnt);
  // The LUT is read before the edge, so a write to the same index in this
  // cycle is seen only from the next cycle on.
  assign lut_rd   = lut[lut_idx];

  // Decode the current op into jump outputs and stack side effects.
  // Everything is forced to 0 while reset is held.
  always_comb begin
    branch_en  = 1'b0;
    reljump_en = 1'b0;
    absjump_en = 1'b0;
    target     = '0;
    do_push    = 1'b0;
    do_pop     = 1'b0;
    do_ovf     = 1'b0;
    do_unf     = 1'b0;
    if (reset && valid) begin
      case (op)
        OP_BEQZ: begin
          if (zero_flag) begin
            branch_en  = 1'b1;
            reljump_en = 1'b1;
            target     = lut_rd;
          end
        end
        OP_BNEZ: begin
          if (!zero_flag) begin
            branch_en  = 1'b1;
            reljump_en = 1'b1;
            target     = lut_rd;
          end
        end
        OP_JREL: begin
          branch_en  = 1'b1;
          reljump_en = 1'b1;
          target     = lut_rd;
        end
        OP_JABS: begin
          branch_en  = 1'b1;
          absjump_en = 1'b1;
          target     = lut_rd;
        end
        OP_CALL: begin
          // A CALL with a full stack still jumps; only the push is lost.
          branch_en  = 1'b1;
          absjump_en = 1'b1;
          target     = lut_rd;
          if (rs_full) do_ovf  = 1'b1;
          else         do_push = 1'b1;
        end
        OP_RET: begin
          if (rs_empty) begin
            do_unf = 1'b1;
          end else begin
            branch_en  = 1'b1;
            absjump_en = 1'b1;
            target     = rs[top_idx];
            do_pop     = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Jump-target LUT write port. It does not depend on valid or op.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 2**L; i++) lut[i] <= '0;
    end else if (lut_we) begin
      lut[lut_waddr] <= lut_wdata;
    end
  end

  // Return-address stack: push prog_ctr+1 on CALL, pop on RET.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < RS_DEPTH; i++) rs[i] <= '0;
      rs_cnt <= '0;
    end else if (do_push) begin
      rs[push_idx] <= prog_ctr + D'(1);
      rs_cnt       <= rs_cnt + CNTW'(1);
    end else if (do_pop) begin
      rs_cnt <= rs_cnt - CNTW'(1);
    end
  end

  // Status: flush echoes the previous cycle's branch_en. The error flags are
  // sticky, and the taken counter stops at its maximum instead of wrapping.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      flush        <= 1'b0;
      rs_overflow  <= 1'b0;
      rs_underflow <= 1'b0;
      taken_cnt    <= '0;
    end else begin
      flush <= branch_en;
      if (do_ovf) rs_overflow  <= 1'b1;
      if (do_unf) rs_underflow <= 1'b1;
      if (branch_en && (taken_cnt != {CW{1'b1}})) taken_cnt <= taken_cnt + CW'(1);
    end
  end

endmodule
